seg_display_mux: RTL and testbench
==================================

SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter REFRESH_HZ, default 1000, per-digit slot rate in Hz; full 8-digit frame = REFRESH_HZ/8.
REQ-003 SHALL have parameter BLINK_HZ, default 2, blink on/off cycle rate in Hz.
REQ-004 SHALL have port clock, input, 1, single clock for all state.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port digits, input, 48, eight 6-bit slots, slot k at bits [6k+5:6k]: bit5 enable, bit4 decimal point, bits3:0 value.
REQ-007 SHALL have port blink_mask, input, 8, bit k set = slot k blinks.
REQ-008 SHALL have port AN, output, 8, active-low anode select, AN[k] drives digit k.
REQ-009 SHALL have port DIGIT, output, 8, active-low cathodes: DIGIT[7:1] = segments a..g, DIGIT[0] = dp.

Function
REQ-010 SHALL generate a one-cycle scan_tick every SLOT_DIV = CLK_FREQ_HZ/REFRESH_HZ cycles using a counter running 0..SLOT_DIV-1.
REQ-011 SHALL advance a 3-bit scan index on scan_tick, wrapping 7 -> 0.
REQ-012 SHALL register AN and DIGIT; both reflect current index and live inputs with exactly 1 cycle latency.
REQ-013 SHALL drive, for the active slot k: AN = all ones except AN[k]=0; DIGIT = decoded value with dp = ~bit4.
REQ-014 SHALL decode values 0-9 to standard digits, 10 to '-' (segment g only), 11-15 to blank (segments all 1).
REQ-015 SHALL blank a slot whose enable bit is 0: AN = 8'hFF, DIGIT = 8'hFF for that slot time; scanning continues.
REQ-016 SHALL never assert more than one AN bit low in any cycle.
REQ-017 SHALL toggle blink_phase every BLINK_DIV = CLK_FREQ_HZ/(2*BLINK_HZ) cycles; blink counter free-runs, independent of scan.
REQ-018 SHALL blank slot k (as REQ-015) while blink_phase=1 and blink_mask[k]=1; blink_mask changes take effect with 1-cycle latency.
REQ-019 SHALL fail elaboration if SLOT_DIV < 2 or BLINK_DIV < 2.

Reset
REQ-020 SHALL, on reset assertion, asynchronously clear slot counter, scan index, blink counter and blink_phase to 0, and set AN = 8'hFF, DIGIT = 8'hFF.
REQ-021 SHALL, after reset release mid-frame, restart at slot 0 with a full SLOT_DIV-cycle slot.
REQ-022 SHALL, on first clock edge after release, show slot 0 per REQ-013.

Configuration
REQ-023 SHALL, with SEG_BLINK_EN defined, implement REQ-017/REQ-018.
REQ-024 SHALL, without SEG_BLINK_EN, omit blink counter and blink_phase logic, ignore blink_mask, and keep all other behaviour identical.

Structure
REQ-025 SHALL take from shared package seg_pkg: digit_slot_t struct (en, dp, val[3:0]), segment code constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK, and val code VAL_DASH=10.
REQ-026 SHALL instantiate one combinational sub-module seg_decoder (4-bit value in, 7-bit active-low segments out).

Verification (CLK_FREQ_HZ=1000, REFRESH_HZ=100 -> SLOT_DIV=10; BLINK_HZ=10 -> BLINK_DIV=50)
REQ-027 SHALL check reset: hold reset 5 cycles -> AN=8'hFF, DIGIT=8'hFF; release -> AN=8'hFE within 1 cycle.
REQ-028 SHALL check scan: all slots enabled, slot k value k -> AN low bit walks 0..7 every 10 cycles, wraps to 0 after 80 cycles; DIGIT for slot 3 = {SEG_3, 1}.
REQ-029 SHALL check decode/blank: slot 2 = val 10 dp=1, slot 5 enable=0 -> slot 2 DIGIT = 8'b1111110_0 (g and dp low); slot 5 AN=8'hFF, DIGIT=8'hFF.
REQ-030 SHALL check blink (SEG_BLINK_EN): blink_mask=8'h01 -> slot 0 visible for cycles 0-49, blanked 50-99, visible 100-149; other slots unaffected.
REQ-031 SHALL check without SEG_BLINK_EN: blink_mask=8'hFF -> all slots visible at every scan.
REQ-032 SHALL check reset mid-operation: assert reset during slot 4 -> outputs 8'hFF immediately (asynchronous); release -> restart at slot 0, blink_phase=0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and segment codes for the 8-digit seven-segment scanner.
// Segment codes are active-low, bit 6 = segment a ... bit 0 = segment g.
package seg_pkg;

  typedef struct packed {
    logic       en;
    logic       dp;
    logic [3:0] val;
  } digit_slot_t;

  localparam logic [3:0] VAL_DASH = 4'd10;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_decoder.sv
// Combinational 4-bit value to active-low seven-segment decoder.
// 0-9 are digits, VAL_DASH shows segment g only, anything else is blank.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);

  // Value lookup; unused codes fall through to blank.
  always_comb begin
    seg = SEG_BLANK;
    case (val)
      4'd0:     seg = SEG_0;
      4'd1:     seg = SEG_1;
      4'd2:     seg = SEG_2;
      4'd3:     seg = SEG_3;
      4'd4:     seg = SEG_4;
      4'd5:     seg = SEG_5;
      4'd6:     seg = SEG_6;
      4'd7:     seg = SEG_7;
      4'd8:     seg = SEG_8;
      4'd9:     seg = SEG_9;
      VAL_DASH: seg = SEG_DASH;
      default:  seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Each digit gets one slot of CLK_FREQ_HZ/REFRESH_HZ cycles; AN and DIGIT are
// registered and reflect the current scan index with one cycle of latency.
// Optional blinking is built only when SEG_BLINK_EN is defined; otherwise
// blink_mask is ignored and no blink timer exists.
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int REFRESH_HZ  = 1000,
  parameter int BLINK_HZ    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [47:0] digits,
  input  logic [7:0]  blink_mask,
  output logic [7:0]  AN,
  output logic [7:0]  DIGIT
);

  localparam int SLOT_DIV  = CLK_FREQ_HZ / REFRESH_HZ;
  localparam int BLINK_DIV = CLK_FREQ_HZ / (2 * BLINK_HZ);

  if (SLOT_DIV < 2) begin : g_slot_div_chk
    $error("seg_display_mux: SLOT_DIV must be at least 2");
  end
  if (BLINK_DIV < 2) begin : g_blink_div_chk
    $error("seg_display_mux: BLINK_DIV must be at least 2");
  end

  localparam int SLOT_W = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;

  logic [SLOT_W-1:0] slot_cnt;
  logic              scan_tick;
  logic [2:0]        scan_idx;
  digit_slot_t       slot;
  logic [6:0]        seg;
  logic              blink_off;

  assign scan_tick = (slot_cnt == SLOT_W'(SLOT_DIV - 1));

  // Slot timer and scan index; index steps once per full slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_cnt <= '0;
      scan_idx <= 3'd0;
    end else if (scan_tick) begin
      slot_cnt <= '0;
      scan_idx <= scan_idx + 3'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  // Free-running blink timer, independent of the scan timer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blink_off = blink_phase & blink_mask[scan_idx];
`else
  logic blink_mask_unused;

  assign blink_mask_unused = ^blink_mask;
  assign blink_off         = 1'b0;
`endif

  assign slot = digit_slot_t'(digits[6*scan_idx +: 6]);

  seg_decoder u_seg_decoder (
    .val (slot.val),
    .seg (seg)
  );

  // Output register: one anode low for an enabled, non-blinked slot, else dark.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      AN    <= 8'hFF;
      DIGIT <= 8'hFF;
    end else if (!slot.en || blink_off) begin
      AN    <= 8'hFF;
      DIGIT <= 8'hFF;
    end else begin
      AN    <= ~(8'b1 << scan_idx);
      DIGIT <= {seg, ~slot.dp};
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed self-checking bench for seg_display_mux with SLOT_DIV=10, BLINK_DIV=50.
// Expected outputs come from edge counts since reset release: slot = (n-1)/10 mod 8,
// blink phase = (n-1)/50 mod 2, with hand-written segment codes.
module tb_seg_display_mux;

  logic        clock;
  logic        reset;
  logic [47:0] digits;
  logic [7:0]  blink_mask;
  logic [7:0]  AN;
  logic [7:0]  DIGIT;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef SEG_BLINK_EN
  localparam bit          BLINK_ON = 1'b1;
  localparam logic [7:0]  RUN_MASK = 8'h01;
`else
  localparam bit          BLINK_ON = 1'b0;
  localparam logic [7:0]  RUN_MASK = 8'hFF;
`endif

  seg_display_mux #(
    .CLK_FREQ_HZ (1000),
    .REFRESH_HZ  (100),
    .BLINK_HZ    (10)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .digits     (digits),
    .blink_mask (blink_mask),
    .AN         (AN),
    .DIGIT      (DIGIT)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      4'd10:   return 7'b1111110;
      default: return 7'b1111111;
    endcase
  endfunction

  // Checks outputs after edges first..last (edge 1 = first edge after release).
  task automatic run_check(input int first, input int last);
    int         s;
    int         ph;
    logic [5:0] sl;
    logic [7:0] exp_an;
    logic [7:0] exp_dig;
    for (int n = first; n <= last; n++) begin
      @(negedge clock);
      s  = ((n - 1) / 10) % 8;
      ph = ((n - 1) / 50) % 2;
      sl = digits[6*s +: 6];
      if (!sl[5] || (BLINK_ON && ph == 1 && blink_mask[s])) begin
        exp_an  = 8'hFF;
        exp_dig = 8'hFF;
      end else begin
        exp_an  = 8'hFF;
        exp_an[s] = 1'b0;
        exp_dig = {seg_ref(sl[3:0]), ~sl[4]};
      end
      check($sformatf("an_n%0d", n), AN, exp_an);
      check($sformatf("digit_n%0d", n), DIGIT, exp_dig);
    end
  endtask

  initial begin
    reset      = 1'b1;
    blink_mask = RUN_MASK;
    for (int k = 0; k < 8; k++) digits[6*k +: 6] = {1'b1, 1'b0, 4'(k)};

    // Reset held
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("rst_an", AN, 8'hFF);
    check("rst_digit", DIGIT, 8'hFF);

    // Scan walk with slot k showing value k
    reset = 1'b0;
    @(negedge clock);
    check("first_an", AN, 8'hFE);
    check("first_digit", DIGIT, 8'b0000001_1);
    run_check(2, 35);
    check("slot3_an", AN, 8'hF7);
    check("slot3_digit", DIGIT, 8'b0000110_1);
    run_check(36, 85);
    check("wrap_an", AN, BLINK_ON ? 8'hFF : 8'hFE);
    run_check(86, 200);

    // Dash with dp, disabled slot
    reset = 1'b1;
    @(negedge clock);
    digits[6*2 +: 6] = {1'b1, 1'b1, 4'd10};
    digits[6*5 +: 6] = {1'b0, 1'b0, 4'd5};
    blink_mask       = 8'h00;
    @(negedge clock);
    reset = 1'b0;
    run_check(1, 25);
    check("dash_an", AN, 8'hFB);
    check("dash_digit", DIGIT, 8'b1111110_0);
    run_check(26, 55);
    check("dis_an", AN, 8'hFF);
    check("dis_digit", DIGIT, 8'hFF);
    run_check(56, 80);

    // Asynchronous reset in slot 4, then restart from slot 0 with phase 0
    blink_mask = RUN_MASK;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    run_check(1, 45);
    #2 reset = 1'b1;
    #1;
    check("async_an", AN, 8'hFF);
    check("async_digit", DIGIT, 8'hFF);
    @(negedge clock);
    @(negedge clock);
    check("hold_an", AN, 8'hFF);
    reset = 1'b0;
    run_check(1, 170);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
